// File: rtl/store_narrow.sv
// Store-data narrowing with two-entry skid buffer toward data memory.
// Optional trap on misaligned stores: define STORE_MISALIGN_TRAP_EN.
module store_narrow #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } beat_t;

  state_t state;
  beat_t  beat;
  beat_t  out_q;
  beat_t  skid_q;
  logic   out_v;
  logic   skid_v;
  logic   sz_b;
  logic   sz_h;
  logic   sz_w;
  logic   rsv;
  logic   acc;
  logic   drain;
  logic   enq;

  assign sz_b = req_size == 2'b00;
  assign sz_h = req_size == 2'b01;
  assign sz_w = req_size == 2'b10;

  // Low address bits only steer lanes; the beat is always word-aligned.
  always_comb begin
    beat       = '0;
    rsv        = 1'b0;
    beat.addr  = {req_addr[ADDR_W-1:2], 2'b00};
    unique case (1'b1)
      sz_b: begin
        beat.wdata = {4{req_data[7:0]}};
        beat.be    = 4'b0001 << req_addr[1:0];
      end
      sz_h: begin
        beat.wdata = {2{req_data[15:0]}};
        beat.be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      sz_w: begin
        beat.wdata = req_data;
        beat.be    = 4'b1111;
      end
      default: rsv = 1'b1;
    endcase
  end

  assign req_ready = !skid_v && !rst;
  assign acc       = req_valid && req_ready;
  assign drain     = out_v && mem_ready;

`ifdef STORE_MISALIGN_TRAP_EN
  logic bad;
  logic mis_q;
  logic [ADDR_W-1:0] mis_addr_q;

  assign bad = rsv
             || (sz_h && req_addr[0])
             || (sz_w && (req_addr[1:0] != 2'b00));
  assign enq = acc && !bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= acc && bad;
      if (acc && bad) mis_addr_q <= req_addr;
    end
  end

  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;
`else
  assign enq           = acc && !rsv;
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (enq) begin
            out_q <= beat;
            out_v <= 1'b1;
            state <= ONE;
          end
        end
        ONE: begin
          if (drain && enq) begin
            out_q <= beat;
          end else if (drain) begin
            out_v <= 1'b0;
            state <= EMPTY;
          end else if (enq) begin
            skid_q <= beat;
            skid_v <= 1'b1;
            state  <= FULL;
          end
        end
        FULL: begin
          if (drain) begin
            out_q  <= skid_q;
            skid_v <= 1'b0;
            state  <= ONE;
          end
        end
        default: begin
          out_v  <= 1'b0;
          skid_v <= 1'b0;
          state  <= EMPTY;
        end
      endcase
    end
  end

  assign mem_valid = out_v;
  assign mem_addr  = out_q.addr;
  assign mem_wdata = out_q.wdata;
  assign mem_be    = out_q.be;

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: directed cases plus random traffic.
// Expected beats come from a lane/enable model of the store rules.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;

  store_narrow #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  be;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mq[$];
  int          pop_cyc[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rnd_rdy = 0;
  bit          stalled = 0;
  logic [67:0] held;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) mem_ready = ($urandom % 4) != 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: byte lanes and enables from the byte offset.
  function automatic void model(input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d);
    exp_t e;
    bit   bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
       || (sz == 2'd2 && a % 4 != 0);
`ifdef STORE_MISALIGN_TRAP_EN
    if (bad) begin
      mq.push_back(a);
      return;
    end
`else
    if (sz == 2'd3) return;
`endif
    e.a = a - (a % 4);
    case (sz)
      2'd0: begin
        e.w  = {24'b0, d[7:0]} * 32'h01010101;
        e.be = 4'(1 << (a % 4));
      end
      2'd1: begin
        e.w  = {16'b0, d[15:0]} * 32'h00010001;
        e.be = 4'(3 << (2 * ((a / 2) % 2)));
      end
      default: begin
        e.w  = d;
        e.be = 4'hf;
      end
    endcase
    sbq.push_back(e);
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checks++;
        if (!mem_valid || {mem_addr, mem_wdata, mem_be} !== held) begin
          errors++;
          $display("FAIL stall_stable: got v=%b %h expected v=1 %h",
                   mem_valid, {mem_addr, mem_wdata, mem_be}, held);
        end
      end
      if (mem_valid && mem_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected none",
                   {mem_addr, mem_wdata, mem_be});
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if ({mem_addr, mem_wdata, mem_be} !== {e.a, e.w, e.be}) begin
            errors++;
            $display("FAIL beat: got %h %h %b expected %h %h %b",
                     mem_addr, mem_wdata, mem_be, e.a, e.w, e.be);
          end
        end
        pop_cyc.push_back(cyc);
      end
      stalled = mem_valid && !mem_ready;
      held    = {mem_addr, mem_wdata, mem_be};
      if (misalign) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_misalign: got addr %h expected none",
                   misalign_addr);
        end else begin
          logic [31:0] ea;
          ea = mq.pop_front();
          if (misalign_addr !== ea) begin
            errors++;
            $display("FAIL misalign_addr: got %h expected %h",
                     misalign_addr, ea);
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output int waited);
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        model(sz, a, d);
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got req_ready=0 expected 1");
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int w;
  int wsum;
  int b0;

  initial begin
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_fields", {mem_addr, mem_wdata}, 64'd0);
    check("rst_be_mis", {58'd0, mem_be, misalign, 1'b0}, 64'd0);
    check("rst_mis_addr", 64'(misalign_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    send(2'd0, 32'h0000_1003, 32'h0000_00A5, w);
    req_valid = 1'b0;
    @(negedge clk);
    check("sb_valid", 64'(mem_valid), 64'd1);
    check("sb_beat", {mem_addr, mem_wdata}, 64'h0000_1000_A5A5_A5A5);
    check("sb_be", 64'(mem_be), 64'b1000);
    @(negedge clk);
    check("sb_one_cycle", 64'(mem_valid), 64'd0);
    idle(1);

    send(2'd1, 32'h0000_2002, 32'h1234_BEEF, w);
    req_valid = 1'b0;
    @(negedge clk);
    check("sh_data", {mem_wdata, 28'd0, mem_be}, 64'hBEEF_BEEF_0000_000C);
    idle(1);
    send(2'd2, 32'h0000_2004, 32'hCAFE_F00D, w);
    req_valid = 1'b0;
    @(negedge clk);
    check("sw_data", {mem_wdata, 28'd0, mem_be}, 64'hCAFE_F00D_0000_000F);
    idle(2);

    mem_ready = 1'b0;
    send(2'd2, 32'h0000_4000, 32'hAAAA_0001, w);
    send(2'd2, 32'h0000_4004, 32'hBBBB_0002, w);
    req_valid = 1'b1;
    req_addr  = 32'h0000_4008;
    req_data  = 32'hCCCC_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    b0 = pop_cyc.size();
    send(2'd2, 32'h0000_4008, 32'hCCCC_0003, w);
    idle(3);
    check("bp_count", 64'(pop_cyc.size() - b0), 64'd3);
    if (pop_cyc.size() - b0 == 3)
      check("bp_consec", 64'(pop_cyc[b0 + 2] - pop_cyc[b0]), 64'd2);

    b0 = pop_cyc.size();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'd2, 32'h0000_5000 + 32'(4 * i), $urandom, w);
      wsum += w;
    end
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("stream_no_wait", 64'(wsum), 64'd0);
    check("stream_count", 64'(pop_cyc.size() - b0), 64'd8);
    if (pop_cyc.size() - b0 == 8)
      check("stream_consec", 64'(pop_cyc[b0 + 7] - pop_cyc[b0]), 64'd7);
    idle(2);

    send(2'd2, 32'h0000_3001, 32'h1357_9BDF, w);
    req_valid = 1'b0;
    @(negedge clk);
`ifdef STORE_MISALIGN_TRAP_EN
    check("trap_pulse", {misalign, mem_valid}, 64'b10);
    check("trap_addr", 64'(misalign_addr), 64'h3001);
    @(negedge clk);
    check("trap_one_cycle", 64'(misalign), 64'd0);
`else
    check("align_beat", {misalign, mem_valid}, 64'b01);
    check("align_addr", {mem_addr, 28'd0, mem_be}, 64'h0000_3000_0000_000F);
`endif
    idle(2);

    mem_ready = 1'b0;
    send(2'd0, 32'h0000_6001, 32'h11, w);
    send(2'd1, 32'h0000_6002, 32'h2222, w);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    @(negedge clk);
    check("rst_mid_valid", 64'(mem_valid), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    b0 = pop_cyc.size();
    idle(5);
    check("rst_no_stale", 64'(pop_cyc.size() - b0), 64'd0);

    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      send(sz, a, $urandom, w);
      if ($urandom % 5 == 0) idle($urandom_range(1, 3));
    end
    req_valid = 1'b0;
    rnd_rdy   = 0;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    idle(10);
    check("drain_beats", 64'(sbq.size()), 64'd0);
    check("drain_misalign", 64'(mq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
# store_narrow

Store-data narrowing unit for the MEM stage: takes a 32-bit register value plus store size (sb/sh/sw) and byte address, and produces a word-aligned data-memory write with replicated lane data and byte enables. It is the write-side counterpart of load sign/zero extension. A two-entry skid buffer with valid/ready handshakes on both sides decouples the pipeline from data-memory back-pressure.

## Interface
- `ADDR_W`, 32: byte address width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: store request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_addr` input ADDR_W: byte address.
- `req_data` input 32: rt register value.
- `mem_valid` output 1: write beat present.
- `mem_ready` input 1: memory accepts beat when `mem_valid && mem_ready`.
- `mem_addr` output ADDR_W: word address, bits [1:0] always 0.
- `mem_wdata` output 32: lane-replicated data.
- `mem_be` output 4: byte enables, bit i covers `mem_wdata[8i+7:8i]`, little-endian.
- `misalign` output 1: one-cycle exception pulse.
- `misalign_addr` output ADDR_W: faulting byte address, held until next fault.

## Operation
- Formatting is combinational on the request and is registered at accept:
  - Byte: wdata = {4{data[7:0]}}, be = 0001 << addr[1:0].
  - Half: wdata = {2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata = data, be = 1111.
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. Reserved size 11 is always dropped and is treated as misaligned.
- Buffer: an output register (OUT) and a skid register (SKID). Each holds {addr, wdata, be, valid}.
  - States: EMPTY (neither valid), ONE (OUT valid), FULL (both valid).
  - `req_ready = !SKID.valid && !rst`.
  - Accept when OUT is empty, or is draining this cycle: the beat loads OUT. Accept while OUT is stalled: the beat loads SKID.
  - OUT drains while SKID is valid: SKID moves to OUT the same cycle.
  - Transitions: EMPTY→ONE on accept. ONE→EMPTY on drain without accept. ONE→FULL on accept without drain. FULL→ONE on drain. Accept and drain in the same ONE cycle stays in ONE.
- Ordering is strictly preserved. The OUT contents and `mem_valid` must not change while `mem_valid && !mem_ready`.

## Timing
- Reset values: `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `misalign`=0, `misalign_addr`=0, both buffer valids=0. `req_ready`=0 while `rst`=1.
- Latency: a request accepted at cycle N appears on `mem_*` at N+1 when the buffer was EMPTY or draining.
- Throughput: one store per cycle while `mem_ready`=1.
- Reset asserted mid-operation discards all buffered beats at the next edge. No partial write is issued after that.
- A misalign pulse asserts at N+1 for a faulting request accepted at N. It occurs regardless of buffer state and does not disturb in-flight beats.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - A misaligned half/word is accepted, consumes the handshake, and is not enqueued.
  - `misalign` pulses and `misalign_addr` captures `req_addr`.
- Not defined:
  - Misaligned half/word is force-aligned (half clears addr[0], word clears addr[1:0]) and enqueued normally.
  - `misalign` is tied 0 and `misalign_addr` stays 0.
  - Reserved size 11 is still dropped silently.

## Test plan
- Reset then sb: `addr=0x1003`, `data=0x000000A5`, `mem_ready`=1. Required: next cycle `mem_addr=0x1000`, `wdata=0xA5A5A5A5`, `be=1000`, `mem_valid`=1 for one cycle.
- sh: `addr=0x2002`, `data=0x1234BEEF`. Required: `wdata=0xBEEFBEEF`, `be=1100`. Then sw to `0x2004`: `wdata` equals data, `be=1111`.
- Back-pressure: `mem_ready`=0, issue three sw (A, B, C). Required: A and B accepted, `req_ready`=0 on C. Raise `mem_ready`: beats A, B, C appear in order on consecutive cycles with stable data while stalled.
- Simultaneous accept and drain in ONE with `mem_ready`=1: a continuous sw stream of 8 beats. Required: 8 beats on 8 consecutive cycles, no bubbles.
- With the macro, sw to `0x3001`. Required: `misalign`=1 for one cycle, `misalign_addr=0x3001`, no `mem_valid`. Without the macro: beat at `0x3000`, `be=1111`, `misalign`=0.
- Assert `rst` while FULL. Required: `mem_valid`=0 and `req_ready`=0 during reset, no stale beat after release.
